// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Holds the fetch FSM encoding, reset vector and IF/ID bus layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;
  localparam int          ID_DATA_W        = 62;
  localparam logic [31:0] NOP              = 32'h0;

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-state / next-pc / IF-ID update select for the fetch stage.
// Priority: IF_STALL over jpcAvail over imem_ack; the registers live in the parent.
module if_pc_next
  import cpu_pkg::*;
(
  input  fetch_state_e           state,
  input  logic [29:0]            pc,
  input  logic [29:0]            addr_q,
  input  logic [31:0]            buf_q,
  input  logic                   stall,
  input  logic [29:0]            jpc,
  input  logic                   jpc_avail,
  input  logic                   ack,
  input  logic [31:0]            rdata,
  output fetch_state_e           state_next,
  output logic [29:0]            pc_next,
  output logic [29:0]            addr_next,
  output logic [31:0]            buf_next,
  output logic                   id_load,
  output logic                   id_valid_next,
  output logic [ID_DATA_W-1:0]   id_data_next,
  output logic                   req,
  output logic [29:0]            req_addr
);

  logic [29:0] pc_inc;

  always_comb begin
    pc_inc        = pc + 30'd1;
    state_next    = state;
    pc_next       = pc;
    addr_next     = addr_q;
    buf_next      = buf_q;
    id_load       = 1'b0;
    id_valid_next = 1'b0;
    id_data_next  = {30'h0, NOP};
    req           = 1'b0;
    req_addr      = pc;

    case (state)
      FETCH: begin
        req = 1'b1;
        if (stall) begin
          if (ack) begin
            buf_next   = rdata;
            state_next = HOLD;
          end
        end else begin
          // Any unstalled cycle rewrites IF/ID; it stays a bubble unless an instruction lands.
          id_load = 1'b1;
          if (jpc_avail) begin
            pc_next = jpc;
            if (!ack) begin
              addr_next  = pc;
              state_next = DROP;
            end
          end else if (ack) begin
            id_valid_next = 1'b1;
            id_data_next  = {pc_inc, rdata};
            pc_next       = pc_inc;
          end
        end
      end

      HOLD: begin
        if (!stall) begin
          id_load    = 1'b1;
          state_next = FETCH;
          if (jpc_avail) begin
            pc_next = jpc;
          end else begin
            id_valid_next = 1'b1;
            id_data_next  = {pc_inc, buf_q};
            pc_next       = pc_inc;
          end
        end
      end

      DROP: begin
        // The wrong-path read cannot be cancelled, so keep presenting its address until it returns.
        req      = 1'b1;
        req_addr = addr_q;
        if (ack) begin
          state_next = FETCH;
        end
        if (!stall) begin
          id_load = 1'b1;
          if (jpc_avail) begin
            pc_next = jpc;
          end
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction memory port
// and registers {PC+1, instr} into the IF/ID bus.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IF_STALL,
  input  logic [29:0]          JPC,
  input  logic                 jpcAvail,
  output logic                 imem_req,
  output logic [29:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [ID_DATA_W-1:0] o_ID_DATA,
  output logic                 o_ID_VALID
);

  fetch_state_e         state_reg;
  fetch_state_e         state_next;
  logic [29:0]          pc_reg;
  logic [29:0]          pc_next;
  logic [29:0]          addr_reg;
  logic [29:0]          addr_next;
  logic [31:0]          buf_reg;
  logic [31:0]          buf_next;
  logic                 id_load;
  logic                 id_valid_next;
  logic [ID_DATA_W-1:0] id_data_next;

  if_pc_next u_pc_next (
    .state         (state_reg),
    .pc            (pc_reg),
    .addr_q        (addr_reg),
    .buf_q         (buf_reg),
    .stall         (IF_STALL),
    .jpc           (JPC),
    .jpc_avail     (jpcAvail),
    .ack           (imem_ack),
    .rdata         (imem_rdata),
    .state_next    (state_next),
    .pc_next       (pc_next),
    .addr_next     (addr_next),
    .buf_next      (buf_next),
    .id_load       (id_load),
    .id_valid_next (id_valid_next),
    .id_data_next  (id_data_next),
    .req           (imem_req),
    .req_addr      (imem_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      addr_reg   <= RESET_PC;
      buf_reg    <= '0;
      o_ID_DATA  <= '0;
      o_ID_VALID <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      buf_reg   <= buf_next;
      if (id_load) begin
        o_ID_DATA  <= id_data_next;
        o_ID_VALID <= id_valid_next;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: cycle-driven memory responses,
// scoreboard of expected IF/ID words popped whenever a new instruction is delivered.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        IF_STALL;
  logic [29:0] JPC;
  logic        jpcAvail;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [61:0] o_ID_DATA;
  logic        o_ID_VALID;

  int          tests_run;
  int          tests_failed;
  logic [61:0] sb_q[$];
  logic [61:0] exp_data;
  logic [29:0] exp_pc;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .IF_STALL   (IF_STALL),
    .JPC        (JPC),
    .jpcAvail   (jpcAvail),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .o_ID_DATA  (o_ID_DATA),
    .o_ID_VALID (o_ID_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    IF_STALL   = 1'b0;
    jpcAvail   = 1'b0;
    JPC        = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
      tests_failed++;
      $display("FAIL reset_idid: got v=%b d=%h want v=0 d=0", o_ID_VALID, o_ID_DATA);
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C00) begin
      tests_failed++;
      $display("FAIL reset_fetch: got req=%b addr=%h want req=1 addr=0c00", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    exp_pc = 30'h0C00;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        tests_failed++;
        $display("FAIL zw_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = {exp_pc, 2'b00};
      sb_q.push_back({exp_pc + 30'd1, exp_pc, 2'b00});
      exp_pc = exp_pc + 30'd1;
      tick();
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL zw_data%0d: scoreboard empty", i);
      end else begin
        exp_data = sb_q.pop_front();
        $display("[TB] zero_wait deliver %h", o_ID_DATA);
        if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
          tests_failed++;
          $display("FAIL zw_data%0d: got v=%b d=%h want v=1 d=%h", i, o_ID_VALID, o_ID_DATA, exp_data);
        end
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_ack();
    do_reset();
    IF_STALL   = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2408_0005;
    sb_q.push_back({30'h0C01, 32'h2408_0005});
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (imem_req !== 1'b0 || o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got req=%b v=%b d=%h want req=0 v=0 d=0", i, imem_req, o_ID_VALID, o_ID_DATA);
      end
      tick();
    end
    IF_STALL = 1'b0;
    tick();
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL stall_release: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] stall_release deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
        tests_failed++;
        $display("FAIL stall_release: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, exp_data);
      end
    end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C01) begin
      tests_failed++;
      $display("FAIL stall_nextaddr: got req=%b addr=%h want req=1 addr=0c01", imem_req, imem_addr);
    end
    // Stall with no ack must freeze a real instruction in IF/ID.
    IF_STALL = 1'b1;
    tick();
    tick();
    tests_run++;
    if (o_ID_VALID !== 1'b1 || o_ID_DATA !== {30'h0C01, 32'h2408_0005} || imem_addr !== 30'h0C01) begin
      tests_failed++;
      $display("FAIL stall_freeze: got v=%b d=%h addr=%h want v=1 d=%h addr=0c01",
               o_ID_VALID, o_ID_DATA, imem_addr, {30'h0C01, 32'h2408_0005});
    end
    IF_STALL = 1'b0;
    tick();
    tests_run++;
    if (o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
      tests_failed++;
      $display("FAIL wait_bubble: got v=%b d=%h want v=0 d=0", o_ID_VALID, o_ID_DATA);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    jpcAvail = 1'b1;
    JPC      = 30'h0D00;
    tick();
    jpcAvail = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 30'h0C00 || o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
        tests_failed++;
        $display("FAIL drop_wait%0d: got req=%b addr=%h v=%b d=%h want req=1 addr=0c00 v=0 d=0",
                 i, imem_req, imem_addr, o_ID_VALID, o_ID_DATA);
      end
      imem_ack   = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      tick();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 30'h0D00 || o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
        tests_failed++;
        $display("FAIL redir_wait%0d: got req=%b addr=%h v=%b d=%h want req=1 addr=0d00 v=0 d=0",
                 i, imem_req, imem_addr, o_ID_VALID, o_ID_DATA);
      end
      imem_ack   = (i == 2);
      imem_rdata = 32'h0000_3400;
      if (i == 2) sb_q.push_back({30'h0D01, 32'h0000_3400});
      tick();
    end
    imem_ack = 1'b0;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL redir_data: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] redirect deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
        tests_failed++;
        $display("FAIL redir_data: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, exp_data);
      end
    end
  endtask

  task automatic test_ack_redirect();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_3000;
    tick();
    tests_run++;
    if (o_ID_VALID !== 1'b1 || o_ID_DATA !== {30'h0C01, 32'h0000_3000}) begin
      tests_failed++;
      $display("FAIL ackj_first: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, {30'h0C01, 32'h0000_3000});
    end
    imem_rdata = 32'h1111_1111;
    jpcAvail   = 1'b1;
    JPC        = 30'h0E00;
    tick();
    jpcAvail = 1'b0;
    tests_run++;
    if (o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0 || imem_req !== 1'b1 || imem_addr !== 30'h0E00) begin
      tests_failed++;
      $display("FAIL ackj_bubble: got v=%b d=%h req=%b addr=%h want v=0 d=0 req=1 addr=0e00",
               o_ID_VALID, o_ID_DATA, imem_req, imem_addr);
    end
    imem_rdata = 32'h0000_3800;
    sb_q.push_back({30'h0E01, 32'h0000_3800});
    tick();
    imem_ack = 1'b0;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL ackj_target: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] ack_redirect deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
        tests_failed++;
        $display("FAIL ackj_target: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, exp_data);
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_3000;
    tick();
    imem_ack = 1'b0;
    IF_STALL = 1'b1;
    jpcAvail = 1'b1;
    JPC      = 30'h0F00;
    tick();
    tick();
    tests_run++;
    if (imem_addr !== 30'h0C01 || o_ID_VALID !== 1'b1 || o_ID_DATA !== {30'h0C01, 32'h0000_3000}) begin
      tests_failed++;
      $display("FAIL stallj_ignored: got addr=%h v=%b d=%h want addr=0c01 v=1 d=%h",
               imem_addr, o_ID_VALID, o_ID_DATA, {30'h0C01, 32'h0000_3000});
    end
    IF_STALL   = 1'b0;
    jpcAvail   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_3004;
    sb_q.push_back({30'h0C02, 32'h0000_3004});
    tick();
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL stallj_next: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] stall_redirect deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
        tests_failed++;
        $display("FAIL stallj_next: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, exp_data);
      end
    end
    jpcAvail = 1'b1;
    tick();
    jpcAvail = 1'b0;
    tests_run++;
    if (imem_addr !== 30'h0F00 || o_ID_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL stallj_taken: got addr=%h v=%b want addr=0f00 v=0", imem_addr, o_ID_VALID);
    end
    // Buffered instruction in HOLD is discarded by a redirect once the stall lifts.
    IF_STALL = 1'b1;
    tick();
    imem_ack = 1'b0;
    IF_STALL = 1'b0;
    jpcAvail = 1'b1;
    JPC      = 30'h0A00;
    tick();
    jpcAvail = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0A00 || o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0) begin
      tests_failed++;
      $display("FAIL hold_redirect: got req=%b addr=%h v=%b d=%h want req=1 addr=0a00 v=0 d=0",
               imem_req, imem_addr, o_ID_VALID, o_ID_DATA);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    jpcAvail   = 1'b1;
    JPC        = 30'h3FFF_FFFF;
    tick();
    jpcAvail = 1'b0;
    tests_run++;
    if (imem_addr !== 30'h3FFF_FFFF) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %h want 3fffffff", imem_addr);
    end
    imem_rdata = 32'hCAFE_F00D;
    sb_q.push_back({30'h0, 32'hCAFE_F00D});
    tick();
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL wrap_data: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] wrap deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data || imem_addr !== 30'h0) begin
        tests_failed++;
        $display("FAIL wrap_data: got v=%b d=%h addr=%h want v=1 d=%h addr=0", o_ID_VALID, o_ID_DATA, imem_addr, exp_data);
      end
    end
    imem_ack = 1'b0;
    IF_STALL = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0 || imem_req !== 1'b1 || imem_addr !== 30'h0C00) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b d=%h req=%b addr=%h want v=0 d=0 req=1 addr=0c00",
               o_ID_VALID, o_ID_DATA, imem_req, imem_addr);
    end
    IF_STALL   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    tick();
    tick();
    imem_ack = 1'b0;
    rst      = 1'b1;
    tests_run++;
    if (o_ID_VALID !== 1'b0 || o_ID_DATA !== 62'h0 || imem_addr !== 30'h0C00) begin
      tests_failed++;
      $display("FAIL reset_ack_lost: got v=%b d=%h addr=%h want v=0 d=0 addr=0c00", o_ID_VALID, o_ID_DATA, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_3000;
    sb_q.push_back({30'h0C01, 32'h0000_3000});
    tick();
    imem_ack = 1'b0;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL restart_data: scoreboard empty");
    end else begin
      exp_data = sb_q.pop_front();
      $display("[TB] restart deliver %h", o_ID_DATA);
      if (o_ID_VALID !== 1'b1 || o_ID_DATA !== exp_data) begin
        tests_failed++;
        $display("FAIL restart_data: got v=%b d=%h want v=1 d=%h", o_ID_VALID, o_ID_DATA, exp_data);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_zero_wait();
    test_stall_ack();
    test_redirect_wait();
    test_ack_redirect();
    test_stall_redirect();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
